vending_core: RTL and testbench

Parametrised vending-machine controller for the FPGA lab platform. It accepts one-pulse coin, selection and cancel events and keeps a saturating credit. It vends one of NUM_ITEMS products at configurable prices, then returns change one coin per tick. Coin and cancel inputs come from the debounce/one-pulse front end and sel_* from the keyboard decoder. The credit output feeds the seven-segment driver; afford feeds the LEDs.

---
 rtl/vending_core.sv | 205 ++++++++++++++++++++
 tb/tb_vending_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_core.sv
`default_nettype none
// ============================================================================
//  Module   : vending_core
//  Purpose  : Vending-machine controller. Accumulates a saturating credit
//             from one-pulse coin events, vends one of NUM_ITEMS products,
//             then returns change one RETURN_COIN per tick.
//  Ports    : clk, rst (async, active-low)
//             coin_in[2:0]  coin pulses, bit k worth COIN_VALUES slice k
//             sel_valid / sel_idx  selection strobe and item index
//             cancel        cancel pulse, returns all credit
//             credit        registered credit
//             afford        combinational, bit i = credit >= price i
//             dispense / dispense_idx, change_pulse, coin_reject, sel_err
//                           registered one-cycle pulses
//             busy          registered, high while in VEND or RETURN
//             credit_bcd    {tens, ones} of credit (VENDING_BCD_EN only)
//  Options  : `define VENDING_BCD_EN adds the credit_bcd output
//             (MAX_CREDIT must then be <= 99).
//  Revision : 1.0  initial release
// ============================================================================
module vending_core #(
    parameter int NUM_ITEMS   = 4,
    parameter int IDX_W       = 3,
    parameter int CREDIT_W    = 7,
    parameter int MAX_CREDIT  = 99,
    // item i occupies bits [i*CREDIT_W +: CREDIT_W]: item 0 = 20 ... item 3 = 60
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {7'd60, 7'd30, 7'd25, 7'd20},
    parameter logic [3*CREDIT_W-1:0] COIN_VALUES = {7'd50, 7'd10, 7'd5},
    parameter int RETURN_COIN = 5,
    parameter int TICK_CYCLES = 100000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          coin_in,
    input  logic                sel_valid,
    input  logic [IDX_W-1:0]    sel_idx,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic [NUM_ITEMS-1:0] afford,
    output logic                dispense,
    output logic [IDX_W-1:0]    dispense_idx,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                sel_err,
`ifdef VENDING_BCD_EN
    output logic [7:0]          credit_bcd,
`endif
    output logic                busy
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0]     c_tick_last = TICK_W'(TICK_CYCLES - 1);
    localparam logic [CREDIT_W+1:0]   c_max_wide  = (CREDIT_W+2)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0]   c_max       = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0]   c_ret_coin  = CREDIT_W'(RETURN_COIN);
    localparam logic [IDX_W:0]        c_num_items = (IDX_W+1)'(NUM_ITEMS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_RETURN = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [TICK_W-1:0]   r_tick, w_tick_nxt;
    logic                w_dispense, w_change, w_reject, w_sel_err;

    logic [CREDIT_W-1:0] w_price [NUM_ITEMS];
    logic [CREDIT_W-1:0] w_sel_price, w_vend_price;
    logic [CREDIT_W-1:0] w_after_vend, w_after_ret, w_ret_amt, w_coin_credit;
    logic [CREDIT_W+1:0] w_coin_sum, w_credit_sum;
    logic                w_sel_ok;

    generate
        for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
            assign w_price[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
            assign afford[gi]  = (r_credit >= w_price[gi]);
        end
    endgenerate

    // Price lookups by decode so an out-of-range index never reads past the table.
    always_comb begin
        w_sel_price  = '0;
        w_vend_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_idx == IDX_W'(i)) w_sel_price  = w_price[i];
            if (r_idx   == IDX_W'(i)) w_vend_price = w_price[i];
        end
    end

    // Coin sum is kept two bits wider than the credit so it cannot wrap
    // before the saturation compare.
    always_comb begin
        w_coin_sum = '0;
        for (int k = 0; k < 3; k++) begin
            if (coin_in[k]) w_coin_sum = w_coin_sum + (CREDIT_W+2)'(COIN_VALUES[k*CREDIT_W +: CREDIT_W]);
        end
    end

    assign w_credit_sum  = {2'b00, r_credit} + w_coin_sum;
    assign w_coin_credit = (w_credit_sum > c_max_wide) ? c_max : w_credit_sum[CREDIT_W-1:0];
    assign w_sel_ok      = ({1'b0, sel_idx} < c_num_items) && (r_credit >= w_sel_price);
    assign w_after_vend  = r_credit - w_vend_price;
    assign w_ret_amt     = (r_credit < c_ret_coin) ? r_credit : c_ret_coin;
    assign w_after_ret   = r_credit - w_ret_amt;

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_idx_nxt    = r_idx;
        w_tick_nxt   = r_tick;
        w_dispense   = 1'b0;
        w_change     = 1'b0;
        w_sel_err    = 1'b0;
        // Coins are rejected unless the IDLE coin-only branch credits them.
        w_reject     = |coin_in;
        case (r_state)
            S_IDLE: begin
                if (cancel) begin
                    if (r_credit != '0) begin
                        w_state_nxt = S_RETURN;
                        w_tick_nxt  = '0;
                    end
                end else if (sel_valid) begin
                    if (w_sel_ok) begin
                        w_state_nxt = S_VEND;
                        w_idx_nxt   = sel_idx;
                    end else begin
                        w_sel_err = 1'b1;
                    end
                end else begin
                    w_reject     = 1'b0;
                    w_credit_nxt = w_coin_credit;
                end
            end
            S_VEND: begin
                w_credit_nxt = w_after_vend;
                w_dispense   = 1'b1;
                w_tick_nxt   = '0;
                w_state_nxt  = (w_after_vend != '0) ? S_RETURN : S_IDLE;
            end
            S_RETURN: begin
                if (r_tick == c_tick_last) begin
                    w_tick_nxt   = '0;
                    w_credit_nxt = w_after_ret;
                    w_change     = 1'b1;
                    if (w_after_ret == '0) w_state_nxt = S_IDLE;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_credit     <= '0;
            r_idx        <= '0;
            r_tick       <= '0;
            dispense     <= 1'b0;
            dispense_idx <= '0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            sel_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_credit     <= w_credit_nxt;
            r_idx        <= w_idx_nxt;
            r_tick       <= w_tick_nxt;
            dispense     <= w_dispense;
            dispense_idx <= w_dispense ? r_idx : '0;
            change_pulse <= w_change;
            coin_reject  <= w_reject;
            sel_err      <= w_sel_err;
            busy         <= (w_state_nxt != S_IDLE);
        end
    end

    assign credit = r_credit;

`ifdef VENDING_BCD_EN
    logic [CREDIT_W-1:0] w_tens, w_ones;
    logic [7:0]          r_bcd;

    // Derived from the next credit so it updates on the same edge as credit.
    assign w_tens = w_credit_nxt / CREDIT_W'(10);
    assign w_ones = w_credit_nxt % CREDIT_W'(10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_bcd <= 8'h00;
        else      r_bcd <= {w_tens[3:0], w_ones[3:0]};
    end

    assign credit_bcd = r_bcd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vending_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vending_core
//  Purpose  : Directed self-checking bench for vending_core with a short
//             change tick (TICK_CYCLES = 4). Inputs change on the falling
//             edge; outputs are sampled on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vending_core;

    localparam int TICK = 4;

    logic       clk;
    logic       rst;
    logic [2:0] coin_in;
    logic       sel_valid;
    logic [2:0] sel_idx;
    logic       cancel;
    logic [6:0] credit;
    logic [3:0] afford;
    logic       dispense;
    logic [2:0] dispense_idx;
    logic       change_pulse;
    logic       coin_reject;
    logic       sel_err;
    logic       busy;
`ifdef VENDING_BCD_EN
    logic [7:0] credit_bcd;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int npulse;

    localparam logic [2:0] C5  = 3'b001;
    localparam logic [2:0] C10 = 3'b010;
    localparam logic [2:0] C50 = 3'b100;

    vending_core #(
        .NUM_ITEMS   (4),
        .IDX_W       (3),
        .CREDIT_W    (7),
        .MAX_CREDIT  (99),
        .PRICES      ({7'd60, 7'd30, 7'd25, 7'd20}),
        .COIN_VALUES ({7'd50, 7'd10, 7'd5}),
        .RETURN_COIN (5),
        .TICK_CYCLES (TICK)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .coin_in      (coin_in),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .cancel       (cancel),
        .credit       (credit),
        .afford       (afford),
        .dispense     (dispense),
        .dispense_idx (dispense_idx),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .sel_err      (sel_err),
`ifdef VENDING_BCD_EN
        .credit_bcd   (credit_bcd),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One-cycle stimulus; returns on the falling edge after the capturing edge.
    task automatic step(input logic [2:0] c, input logic sv, input logic [2:0] si, input logic cn);
        @(negedge clk);
        coin_in   = c;
        sel_valid = sv;
        sel_idx   = si;
        cancel    = cn;
        @(negedge clk);
        coin_in   = 3'b000;
        sel_valid = 1'b0;
        sel_idx   = 3'd0;
        cancel    = 1'b0;
    endtask

    // Counts change pulses until busy drops. first_ref = 0 measures the
    // first gap from the call; -1 skips the first gap.
    task automatic drain(input int first_ref, output int np);
        int  last;
        bit  done;
        np   = 0;
        last = first_ref;
        done = 1'b0;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            @(negedge clk);
            if (change_pulse) begin
                if (last >= 0) check("pulse_gap", cyc - last, TICK);
                last = cyc;
                np++;
            end
            if (!busy) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        coin_in   = 3'b000;
        sel_valid = 1'b0;
        sel_idx   = 3'd0;
        cancel    = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_dispense", dispense, 0);
        check("rst_afford", afford, 4'b0000);
        rst = 1'b1;

        // Basic vend with no change
        step(C50, 0, 0, 0);
        check("t1_credit50", credit, 50);
        check("t1_afford50", afford, 4'b0111);
        step(C10, 0, 0, 0);
        check("t1_credit60", credit, 60);
        check("t1_afford60", afford, 4'b1111);
        check("t1_reject", coin_reject, 0);
        step(3'b000, 1, 3'd3, 0);
        check("t1_busy_vend", busy, 1);
        @(negedge clk);
        check("t1_dispense", dispense, 1);
        check("t1_disp_idx", dispense_idx, 3);
        check("t1_credit0", credit, 0);
        check("t1_busy_idle", busy, 0);
        npulse = 0;
        repeat (6) begin
            @(negedge clk);
            if (change_pulse) npulse++;
        end
        check("t1_no_change", npulse, 0);

        // Vend with change
        step(C50 | C10 | C5, 0, 0, 0);
        check("t2_credit65", credit, 65);
        step(3'b000, 1, 3'd1, 0);
        @(negedge clk);
        check("t2_dispense", dispense, 1);
        check("t2_disp_idx", dispense_idx, 1);
        check("t2_credit40", credit, 40);
        check("t2_afford40", afford, 4'b0111);
        check("t2_busy", busy, 1);
        drain(0, npulse);
        check("t2_pulses", npulse, 8);
        check("t2_credit_end", credit, 0);
        check("t2_busy_end", busy, 0);

        // Saturation
        step(C50 | C10 | C5, 0, 0, 0);
        step(C10, 0, 0, 0);
        step(C10, 0, 0, 0);
        step(C10, 0, 0, 0);
        check("t3_credit95", credit, 95);
`ifdef VENDING_BCD_EN
        check("t3_bcd95", credit_bcd, 8'h95);
`endif
        step(C10, 0, 0, 0);
        check("t3_credit99", credit, 99);
        check("t3_reject_a", coin_reject, 0);
        step(C50, 0, 0, 0);
        check("t3_credit_sat", credit, 99);
        check("t3_reject_b", coin_reject, 0);
`ifdef VENDING_BCD_EN
        check("t3_bcd99", credit_bcd, 8'h99);
`endif
        step(3'b000, 0, 0, 1);
        drain(0, npulse);
        check("t3_pulses", npulse, 20);
        check("t3_credit_end", credit, 0);

        // Refused selections, then cancel
        step(C10 | C5, 0, 0, 0);
        check("t4_credit15", credit, 15);
        check("t4_afford15", afford, 4'b0000);
        step(3'b000, 1, 3'd0, 0);
        check("t4_sel_err_a", sel_err, 1);
        check("t4_credit_keep", credit, 15);
        check("t4_busy", busy, 0);
        step(3'b000, 1, 3'd5, 0);
        check("t4_sel_err_b", sel_err, 1);
        check("t4_dispense", dispense, 0);
        step(3'b000, 0, 0, 1);
        drain(0, npulse);
        check("t4_pulses", npulse, 3);
        check("t4_credit_end", credit, 0);

        // Coins rejected on cancel and during RETURN
        step(C10, 0, 0, 0);
        step(C10, 0, 0, 0);
        check("t5_credit20", credit, 20);
        step(C10, 0, 0, 1);
        check("t5_reject_cancel", coin_reject, 1);
        check("t5_busy", busy, 1);
        check("t5_credit_kept", credit, 20);
        step(C10, 0, 0, 0);
        check("t5_reject_ret", coin_reject, 1);
        check("t5_credit_ret", credit, 20);
        drain(-1, npulse);
        check("t5_pulses", npulse, 4);
        check("t5_credit_end", credit, 0);

        // Asynchronous reset in the middle of RETURN
        step(C10 | C5, 0, 0, 0);
        step(C10, 0, 0, 0);
        step(C10, 0, 0, 0);
        check("t6_credit35", credit, 35);
        step(3'b000, 0, 0, 1);
        check("t6_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_credit", credit, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_change", change_pulse, 0);
        @(negedge clk);
        rst = 1'b1;
        npulse = 0;
        repeat (8) begin
            @(negedge clk);
            if (change_pulse) npulse++;
        end
        check("t6_no_pulse", npulse, 0);
        check("t6_credit_idle", credit, 0);
        check("t6_busy_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
